// File: rtl/prefix_enc.sv
// ============================================================================
// Module  : prefix_enc
// Brief   : Inserts REP / segment-override / operand-size prefix bytes ahead of
//           an instruction body, one prefix per cycle, then holds the packet.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prefix_enc (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_rep,
  input  logic [5:0]   in_seg_override,
  input  logic         in_opsize_override,
  input  logic [127:0] in_body,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_packet,
  output logic [1:0]   out_num_prefixes,
  output logic         out_err
);

  localparam logic [7:0] C_REP    = 8'hF3;
  localparam logic [7:0] C_ES     = 8'h26;
  localparam logic [7:0] C_CS     = 8'h2E;
  localparam logic [7:0] C_SS     = 8'h36;
  localparam logic [7:0] C_DS     = 8'h3E;
  localparam logic [7:0] C_FS     = 8'h64;
  localparam logic [7:0] C_GS     = 8'h65;
  localparam logic [7:0] C_OPSIZE = 8'h66;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [127:0] r_packet;
  logic [2:0]   r_pend;        // [0] opsize, [1] seg, [2] rep
  logic [7:0]   r_seg_byte;
  logic [1:0]   r_num;
  logic         r_err;

  logic         w_seg_multi;
  logic         w_seg_one;
  logic [7:0]   w_seg_byte;
  logic [7:0]   w_ins_byte;
  logic [2:0]   w_pend_next;
  logic         w_accept;

  // x & (x-1) clears the lowest set bit: non-zero result means two or more set
  assign w_seg_multi = (in_seg_override & (in_seg_override - 6'd1)) != 6'd0;
  assign w_seg_one   = (in_seg_override != 6'd0) && !w_seg_multi;
  assign w_accept    = in_valid && (r_state == S_IDLE);

  always_comb begin
    w_seg_byte = 8'h00;
    case (in_seg_override)
      6'b000001: w_seg_byte = C_ES;
      6'b000010: w_seg_byte = C_CS;
      6'b000100: w_seg_byte = C_SS;
      6'b001000: w_seg_byte = C_DS;
      6'b010000: w_seg_byte = C_FS;
      6'b100000: w_seg_byte = C_GS;
      default:   w_seg_byte = 8'h00;
    endcase
  end

  // Opsize goes in first so that it ends up nearest the opcode
  always_comb begin
    w_ins_byte  = C_REP;
    w_pend_next = r_pend;
    if (r_pend[0]) begin
      w_ins_byte     = C_OPSIZE;
      w_pend_next[0] = 1'b0;
    end else if (r_pend[1]) begin
      w_ins_byte     = r_seg_byte;
      w_pend_next[1] = 1'b0;
    end else if (r_pend[2]) begin
      w_ins_byte     = C_REP;
      w_pend_next[2] = 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_rep || w_seg_one || in_opsize_override) w_state_next = S_PREP;
          else                                            w_state_next = S_DONE;
        end
      end
      S_PREP: begin
        if (w_pend_next == 3'b000) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_packet   <= 128'd0;
      r_pend     <= 3'b000;
      r_seg_byte <= 8'h00;
      r_num      <= 2'd0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_packet   <= in_body;
      r_pend     <= {in_rep, w_seg_one, in_opsize_override};
      r_seg_byte <= w_seg_byte;
      r_num      <= {1'b0, in_rep} + {1'b0, w_seg_one} + {1'b0, in_opsize_override};
      r_err      <= w_seg_multi;
    end else if (r_state == S_PREP) begin
      r_packet   <= {w_ins_byte, r_packet[127:8]};
      r_pend     <= w_pend_next;
    end
  end

  assign out_packet       = r_packet;
  assign out_num_prefixes = r_num;
  assign out_err          = r_err;

endmodule

`default_nettype wire
